fp_add_arbiter: RTL

- Round-robin arbiter and sequencer that shares one floatingPointAdder instance among N_REQ requesters.
- Grants one request at a time and latches the winner's IEEE-754 single-precision operands.
- Drives the adder start/done handshake and returns the sum to the winner with a one-cycle ack.
- Sits between the requester blocks and the single adder instance.

---
 rtl/fp_add_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter/sequencer sharing one FP adder among N_REQ requesters.
// Optional adder watchdog enabled by defining FP_ADD_ARB_TIMEOUT_EN.
module fp_add_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  a_in,
    input  logic [32*N_REQ-1:0]  b_in,
    output logic [N_REQ-1:0]     ack,
    output logic [31:0]          result,
    output logic                 err,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    output logic                 add_start,
    input  logic                 add_done,
    input  logic [31:0]          add_ans
);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("fp_add_arbiter: N_REQ must be 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fp_add_arbiter: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             state, state_d;
    logic [2:0]         rr_ptr, rr_d, grant_d, win;
    logic [31:0]        a_d, b_d, result_d, a_sel, b_sel;
    logic [N_REQ-1:0]   ack_d, gnt_oh;
    logic               start_d, busy_d;

`ifdef FP_ADD_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]    wd, wd_d;
    logic               err_d;
`endif

    // First set request at or above p, otherwise the lowest set request (wrap).
    function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] r, input logic [2:0] p);
        logic [2:0] lo, hi;
        logic       hi_found;
        lo = '0;
        hi = '0;
        hi_found = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (r[i]) lo = 3'(i);
            if (r[i] && 3'(i) >= p) begin
                hi = 3'(i);
                hi_found = 1'b1;
            end
        end
        return hi_found ? hi : lo;
    endfunction

    always_comb begin
        win   = rr_pick(req, rr_ptr);
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            gnt_oh[i] = (grant_id == 3'(i));
            if (win == 3'(i)) begin
                a_sel = a_in[32*i +: 32];
                b_sel = b_in[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d  = state;
        grant_d  = grant_id;
        a_d      = add_a;
        b_d      = add_b;
        start_d  = 1'b0;
        ack_d    = '0;
        result_d = result;
        rr_d     = rr_ptr;
`ifdef FP_ADD_ARB_TIMEOUT_EN
        wd_d     = wd;
        err_d    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_ISSUE;
                    grant_d = win;
                    a_d     = a_sel;
                    b_d     = b_sel;
                    start_d = 1'b1;
`ifdef FP_ADD_ARB_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (add_done) begin
                    result_d = add_ans;
                    ack_d    = gnt_oh;
                    state_d  = S_RESP;
                end
`ifdef FP_ADD_ARB_TIMEOUT_EN
                // Adder never answered: return quiet NaN and flag the timeout.
                else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    result_d = 32'h7FC0_0000;
                    err_d    = 1'b1;
                    ack_d    = gnt_oh;
                    state_d  = S_RESP;
                end else begin
                    wd_d = wd + 1'b1;
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
                rr_d    = (grant_id == 3'(N_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_start <= 1'b0;
            ack       <= '0;
            result    <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_d;
            grant_id  <= grant_d;
            add_a     <= a_d;
            add_b     <= b_d;
            add_start <= start_d;
            ack       <= ack_d;
            result    <= result_d;
            busy      <= busy_d;
        end
    end

`ifdef FP_ADD_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd  <= '0;
            err <= 1'b0;
        end else begin
            wd  <= wd_d;
            err <= err_d;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
